bus_cycle_sequencer: RTL and testbench

BUS_CYCLE_SEQUENCER -- requirements
Module: bus_cycle_sequencer

---
 rtl/bus_cycle_sequencer_pkg.sv | 39 +++
 rtl/bus_cycle_sequencer_wait_counter.sv | 42 ++++
 rtl/bus_cycle_sequencer.sv | 131 +++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_cycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_cycle_sequencer_pkg
// Brief   : T-state codes shared with the bus interface unit, sequencer states
// Revision: 1.0
// ============================================================================
package bus_cycle_sequencer_pkg;

    localparam logic [2:0] c_TS_TI = 3'b111;
    localparam logic [2:0] c_TS_T1 = 3'b000;
    localparam logic [2:0] c_TS_T2 = 3'b010;
    localparam logic [2:0] c_TS_T3 = 3'b011;
    localparam logic [2:0] c_TS_TW = 3'b100;
    localparam logic [2:0] c_TS_T4 = 3'b110;

    typedef enum logic [2:0] {
        ST_TI = 3'd0,
        ST_TR = 3'd1,
        ST_T1 = 3'd2,
        ST_T2 = 3'd3,
        ST_T3 = 3'd4,
        ST_TW = 3'd5,
        ST_T4 = 3'd6
    } state_e;

    // TR shares the idle code so the bus unit sees busint/dtr_ settle first.
    function automatic logic [2:0] t_code(input state_e s);
        case (s)
            ST_T1:   t_code = c_TS_T1;
            ST_T2:   t_code = c_TS_T2;
            ST_T3:   t_code = c_TS_T3;
            ST_TW:   t_code = c_TS_TW;
            ST_T4:   t_code = c_TS_T4;
            default: t_code = c_TS_TI;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_cycle_sequencer_wait_counter.sv
`default_nettype none
// ============================================================================
// Module  : wait_counter
// Brief   : 4-bit wait-state counter with timeout compare against MAX_WAIT
// Revision: 1.0
// ============================================================================
module wait_counter #(
    parameter int MAX_WAIT = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [3:0] c_MAX = 4'(MAX_WAIT);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 4'd0;
        end else if (enable) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout = (count_q >= c_MAX);

endmodule
`default_nettype wire

// File: rtl/bus_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : bus_cycle_sequencer
// Brief   : T-state sequencer for one bus cycle with wait states and timeout
// Revision: 1.0
// ============================================================================
module bus_cycle_sequencer
    import bus_cycle_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        ready,
    input  logic [15:0] din,
    output logic [2:0]  t_state,
    output logic        busint,
    output logic        dtr_,
    output logic [15:0] aout,
    output logic [15:0] dout,
    output logic        dout_oe,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_e      state_q, state_d;
    logic        dtr_q, dtr_d;
    logic [15:0] aout_q, aout_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        w_wait_clear;
    logic        w_wait_en;
    logic        w_timeout;

    assign w_wait_clear = (state_q == ST_TI);

    wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_wait_clear),
        .enable  (w_wait_en),
        .timeout (w_timeout)
    );

    always_comb begin
        state_d   = state_q;
        dtr_d     = dtr_q;
        aout_d    = aout_q;
        dout_d    = dout_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        done_d    = (state_q == ST_T4);
        w_wait_en = 1'b0;
        case (state_q)
            ST_TI: begin
                if (req) begin
                    state_d = ST_TR;
                    dtr_d   = wr;
                    aout_d  = addr;
                    dout_d  = wdata;
                    err_d   = 1'b0;
                end
            end
            ST_TR: state_d = ST_T1;
            ST_T1: state_d = ST_T2;
            ST_T2: state_d = ST_T3;
            ST_T3, ST_TW: begin
                if (ready) begin
                    state_d = ST_T4;
                    if (!dtr_q) begin
                        rdata_d = din;
                    end
                end else if (!w_timeout) begin
                    // The counter is cleared in TI, so T3 never sees a timeout.
                    state_d   = ST_TW;
                    w_wait_en = 1'b1;
                end else begin
                    state_d = ST_T4;
                    err_d   = 1'b1;
                    rdata_d = 16'h0000;
                end
            end
            ST_T4:   state_d = ST_TI;
            default: state_d = ST_TI;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_TI;
            dtr_q   <= 1'b0;
            aout_q  <= 16'h0000;
            dout_q  <= 16'h0000;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dtr_q   <= dtr_d;
            aout_q  <= aout_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign t_state = t_code(state_q);
    assign busy    = (state_q != ST_TI);
    assign busint  = (state_q != ST_TI);
    assign dtr_    = dtr_q;
    assign aout    = aout_q;
    assign dout    = dout_q;
    assign dout_oe = dtr_q && ((state_q == ST_T2) || (state_q == ST_T3) ||
                               (state_q == ST_TW) || (state_q == ST_T4));
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_cycle_sequencer
// Brief   : Scoreboard bench for bus_cycle_sequencer with a cycle-level model
// Revision: 1.0
// ============================================================================
module tb_bus_cycle_sequencer;

    localparam int MAX_WAIT = 7;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr, ready;
    logic [15:0] addr, wdata, din;
    logic [2:0]  t_state;
    logic        busint, dtr_, dout_oe, busy, done, err;
    logic [15:0] aout, dout, rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    logic [2:0]  seq_q[$];
    logic [15:0] model_rdata = 16'h0000;

    bus_cycle_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(ready), .din(din), .t_state(t_state), .busint(busint), .dtr_(dtr_),
        .aout(aout), .dout(dout), .dout_oe(dout_oe), .rdata(rdata), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Nominal bus cycle seen from the bus unit: TR,T1,T2,T3,(TW x waits),T4.
    function automatic int expected_code(input int idx, input int waits);
        if (idx == 0) return 3'b111;
        if (idx == 1) return 3'b000;
        if (idx == 2) return 3'b010;
        if (idx == 3) return 3'b011;
        if (idx < 4 + waits) return 3'b100;
        return 3'b110;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            seq_q.delete();
        end else begin
            check("busint_eq_busy", 32'(busint), 32'(busy));
            if (busy) begin
                seq_q.push_back(t_state);
                if (exp_q.size() == 0) begin
                    check("busy_without_request", 32'(busy), 32'd0);
                end else begin
                    check("aout_held", 32'(aout), 32'(exp_q[0].addr));
                    check("dtr_held", 32'(dtr_), 32'(exp_q[0].wr));
                    check("dout_held", 32'(dout), 32'(exp_q[0].wdata));
                    check("dout_oe", 32'(dout_oe), 32'(exp_q[0].wr &&
                          (t_state == 3'b010 || t_state == 3'b011 ||
                           t_state == 3'b100 || t_state == 3'b110)));
                end
            end else begin
                check("dout_oe_idle", 32'(dout_oe), 32'd0);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_without_request", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rdata", 32'(rdata), 32'(e.rdata));
                    check("err", 32'(err), 32'(e.err));
                    check("latency", 32'(seq_q.size() + 1), 32'(6 + e.waits));
                    for (int i = 0; i < seq_q.size() && i < 5 + e.waits; i++)
                        check("t_state_seq", 32'(seq_q[i]), 32'(expected_code(i, e.waits)));
                end
                seq_q.delete();
            end
        end
    end

    task automatic wait_accept(output int cycles);
        bit ok = 0;
        cycles = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (busy && t_state == 3'b111) ok = 1;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_txn(input logic t_wr, input logic [15:0] t_addr, input logic [15:0] t_wdata,
                          input logic [15:0] t_din, input int k, input bit b2b,
                          input bit pulse_t2, output int acc_cycles);
        exp_t e;
        int   cnt;
        bit   ok;
        wr = t_wr; addr = t_addr; wdata = t_wdata; din = t_din;
        ready = 1'($urandom); req = 1'b1;
        wait_accept(acc_cycles);
        e.wr = t_wr; e.addr = t_addr; e.wdata = t_wdata;
        e.err   = (k > MAX_WAIT);
        e.waits = (k > MAX_WAIT) ? MAX_WAIT : k;
        e.rdata = e.err ? 16'h0000 : (t_wr ? model_rdata : t_din);
        model_rdata = e.rdata;
        exp_q.push_back(e);
        if (!b2b) req = 1'b0;
        ok = 0;
        for (int i = 0; i < 5 && !ok; i++) begin
            @(posedge clk); #1;
            if (t_state == 3'b010) ok = 1;
        end
        check("reach_t2", 32'(ok), 32'd1);
        ready = 1'($urandom);
        if (pulse_t2) begin
            req = 1'b1; addr = ~t_addr; wr = ~t_wr; wdata = ~t_wdata;
        end
        @(posedge clk); #1;
        if (pulse_t2) req = 1'b0;
        check("reach_t3", 32'(t_state), 32'(3'b011));
        cnt = 0;
        for (int i = 0; i < 40 && (t_state == 3'b011 || t_state == 3'b100); i++) begin
            ready = (cnt >= k);
            @(posedge clk); #1;
            cnt++;
        end
        check("reach_t4", 32'(t_state), 32'(3'b110));
        if (!b2b) begin
            @(posedge clk); #1;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_values();
        check("rst_t_state", 32'(t_state), 32'(3'b111));
        check("rst_busint", 32'(busint), 32'd0);
        check("rst_dtr", 32'(dtr_), 32'd0);
        check("rst_dout_oe", 32'(dout_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_aout", 32'(aout), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit ok;
        rst = 1'b1; req = 1'b0; wr = 1'b0; ready = 1'b0;
        addr = 16'h0; wdata = 16'h0; din = 16'h0;
        #12;
        check_reset_values();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Read, ready immediately in T3.
        do_txn(1'b0, 16'h0042, 16'h0000, 16'hA5C3, 0, 1'b0, 1'b0, acc);
        // Write with ready low for two T3/TW clocks.
        do_txn(1'b1, 16'h1234, 16'hBEEF, 16'h0F0F, 2, 1'b0, 1'b0, acc);
        // Read that times out.
        do_txn(1'b0, 16'h2222, 16'h0000, 16'h7777, 100, 1'b0, 1'b0, acc);
        // Read following a timeout: err must clear.
        do_txn(1'b0, 16'h3333, 16'h0000, 16'h1357, MAX_WAIT, 1'b0, 1'b0, acc);
        // Back-to-back with req held high.
        do_txn(1'b0, 16'hAAAA, 16'h0000, 16'h1111, 0, 1'b1, 1'b0, acc);
        do_txn(1'b1, 16'h5555, 16'hCAFE, 16'h2222, 1, 1'b0, 1'b0, acc);
        check("b2b_accept_cycles", 32'(acc), 32'd2);
        // Request pulsed during T2 is ignored.
        do_txn(1'b0, 16'h6789, 16'h0000, 16'h4321, 0, 1'b0, 1'b1, acc);
        repeat (3) @(posedge clk);
        #1;
        check("no_second_cycle", 32'(busy), 32'd0);

        // Reset asserted during a wait state.
        wr = 1'b0; addr = 16'h5A5A; din = 16'h1111; req = 1'b1;
        wait_accept(acc);
        begin
            exp_t e;
            e.wr = 1'b0; e.addr = 16'h5A5A; e.wdata = wdata; e.rdata = 16'h0; e.err = 1'b0; e.waits = 0;
            exp_q.push_back(e);
        end
        req = 1'b0; ready = 1'b0;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(posedge clk); #1;
            if (t_state == 3'b100) ok = 1;
        end
        check("reach_tw_before_reset", 32'(ok), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values();
        exp_q.delete();
        model_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("no_done_after_reset", 32'(done), 32'd0);
        end
        do_txn(1'b0, 16'h0BAD, 16'h0000, 16'h9876, 1, 1'b0, 1'b0, acc);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            logic        r_wr;
            int          k;
            r_wr = 1'($urandom);
            k    = ($urandom_range(0, 5) == 0) ? 20 : int'($urandom_range(0, 9));
            do_txn(r_wr, 16'($urandom), 16'($urandom), 16'($urandom), k,
                   1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0), acc);
        end
        req = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
